// File: rtl/dense_collector.sv
// Collects one dense-layer output vector into a buffer while tracking the signed
// running maximum, then holds results until the host clears them.
module dense_collector #(
    parameter int N  = 32,
    parameter int W  = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          done,
    output logic          len_err,
    output logic [AW-1:0] argmax_idx,
    output logic [W-1:0]  max_val,
    input  logic          clear,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    localparam logic [AW-1:0] LP_LAST  = AW'(N - 1);
    localparam logic [AW:0]   LP_N_EXT = (AW + 1)'(N);

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic [W-1:0]    r_buf [N];

    logic            w_accept;
    logic            w_last_slot;
    logic            w_vec_end;
    logic            w_greater;
    logic            w_rd_in_range;

    assign in_ready = (r_state == ST_COLLECT);

    // Accept qualification; a same-cycle clear suppresses the write.
    always_comb begin
        w_accept      = 1'b0;
        w_last_slot   = 1'b0;
        w_vec_end     = 1'b0;
        w_greater     = 1'b0;
        w_rd_in_range = 1'b0;
        if (in_valid && (r_state == ST_COLLECT) && !clear) begin
            w_accept = 1'b1;
        end else begin
            w_accept = 1'b0;
        end
        w_last_slot   = (r_cnt == LP_LAST);
        w_vec_end     = w_last_slot || in_last;
        w_greater     = ($signed(in_data) > $signed(max_val));
        w_rd_in_range = ({1'b0, rd_addr} < LP_N_EXT);
    end

    // Collect/hold control, running max and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_COLLECT;
            r_cnt      <= '0;
            done       <= 1'b0;
            len_err    <= 1'b0;
            argmax_idx <= '0;
            max_val    <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (clear) begin
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        // Element 0 seeds the max; strict > keeps the lowest index on ties.
                        if ((r_cnt == '0) || w_greater) begin
                            max_val    <= in_data;
                            argmax_idx <= r_cnt;
                        end
                        if (w_vec_end) begin
                            r_cnt   <= '0;
                            r_state <= ST_HOLD;
                            done    <= 1'b1;
                            len_err <= (in_last != w_last_slot);
                        end else begin
                            r_cnt <= r_cnt + AW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (clear) begin
                        r_state <= ST_COLLECT;
                        r_cnt   <= '0;
                        done    <= 1'b0;
                        len_err <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                    r_cnt   <= '0;
                    done    <= 1'b0;
                    len_err <= 1'b0;
                end
            endcase
        end
    end

    // Element buffer; intentionally not reset so short vectors keep stale entries.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_buf[r_cnt] <= in_data;
        end
    end

    // Registered readback; same-cycle write is not visible until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (w_rd_in_range) begin
            rd_data <= r_buf[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_dense_collector.sv
// Scoreboard bench for dense_collector: stimulus pushes expected results and
// reads into queues, a negedge monitor pops and compares them.
module tb_dense_collector;

    localparam int N  = 32;
    localparam int W  = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          done;
    logic          len_err;
    logic [AW-1:0] argmax_idx;
    logic [W-1:0]  max_val;
    logic          clear;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;

    always #5 clk = ~clk;

    dense_collector #(.N(N), .W(W), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .done       (done),
        .len_err    (len_err),
        .argmax_idx (argmax_idx),
        .max_val    (max_val),
        .clear      (clear),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [W-1:0]  val;
        logic          err;
    } res_t;

    int           errors = 0;
    int           checks = 0;
    res_t         res_q[$];
    logic [W-1:0] rd_q[$];
    logic         rd_chk   = 1'b0;
    logic         rd_chk_d = 1'b0;
    logic         done_q   = 1'b0;
    res_t         mon_e;
    logic [W-1:0] mon_rd;
    logic [W-1:0] vec    [N];
    logic [W-1:0] shadow [N];
    bit           shadow_ok [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_res(input logic [AW-1:0] idx, input logic [W-1:0] val, input logic err);
        res_t r;
        r.idx = idx;
        r.val = val;
        r.err = err;
        res_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic [W-1:0] exp);
        rd_addr = addr;
        rd_chk  = 1'b1;
        rd_q.push_back(exp);
        tick();
        rd_chk  = 1'b0;
    endtask

    // Sends vec[0..n-1]; element 0 also reads address 0 to check read-before-write.
    task automatic send(input int n, input int last_pos);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            in_last  = (i == last_pos);
            if (i == 0) begin
                chk("in_ready_collect", 32'(in_ready), 32'd1);
                if (shadow_ok[0]) begin
                    rd_addr = 5'd0;
                    rd_chk  = 1'b1;
                    rd_q.push_back(shadow[0]);
                end
            end
            tick();
            rd_chk    = 1'b0;
            shadow[i] = vec[i];
            shadow_ok[i] = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 4 && !done; k++) tick();
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    always @(posedge clk) rd_chk_d <= rd_chk;

    // Monitor: results on each rising done, read data one cycle after a read.
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (res_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result");
            end else begin
                mon_e = res_q.pop_front();
                chk("argmax_idx", 32'(argmax_idx), 32'(mon_e.idx));
                chk("max_val", 32'(max_val), 32'(mon_e.val));
                chk("len_err", 32'(len_err), 32'(mon_e.err));
            end
        end
        done_q <= done;
        if (rd_chk_d) begin
            mon_rd = rd_q.pop_front();
            chk("rd_data", 32'(rd_data), 32'(mon_rd));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        clear = 1'b0; rd_addr = '0;
        for (int i = 0; i < N; i++) shadow_ok[i] = 1'b0;
        repeat (3) tick();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        chk("rst_argmax", 32'(argmax_idx), 32'd0);
        chk("rst_max_val", 32'(max_val), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Full vector, peak 0x00C4 at index 4
        for (int i = 0; i < N; i++) vec[i] = 16'(i);
        vec[4] = 16'h00C4;
        expect_res(5'd4, 16'h00C4, 1'b0);
        send(32, 31);
        wait_done();
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
            in_data  = 16'h7FFF;
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("hold_argmax", 32'(argmax_idx), 32'd4);
        chk("hold_max_val", 32'(max_val), 32'h00C4);
        rd(5'd4, 16'h00C4);
        rd(5'd31, 16'h001F);
        rd(5'd0, 16'h0000);
        pulse_clear();
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);

        // Signed comparison: -128 at 0, +1 at 9, rest -2
        for (int i = 0; i < N; i++) vec[i] = 16'hFFFE;
        vec[0] = 16'hFF80;
        vec[9] = 16'h0001;
        expect_res(5'd9, 16'h0001, 1'b0);
        send(32, 31);
        wait_done();
        pulse_clear();

        // All equal: lowest index wins
        for (int i = 0; i < N; i++) vec[i] = 16'hFFFB;
        expect_res(5'd0, 16'hFFFB, 1'b0);
        send(32, 31);
        wait_done();
        pulse_clear();

        // Short vector ending on element 9
        for (int i = 0; i < 10; i++) vec[i] = 16'h0010 + 16'(i);
        vec[7] = 16'h0100;
        expect_res(5'd7, 16'h0100, 1'b1);
        send(10, 9);
        wait_done();
        chk("short_in_ready", 32'(in_ready), 32'd0);
        chk("short_len_err", 32'(len_err), 32'd1);
        rd(5'd20, 16'hFFFB);
        rd(5'd7, 16'h0100);
        pulse_clear();
        chk("short_clr_done", 32'(done), 32'd0);
        chk("short_clr_ready", 32'(in_ready), 32'd1);

        // Abort in COLLECT with a same-cycle accept, then full vector without in_last
        for (int i = 0; i < 5; i++) vec[i] = 16'h7000 + 16'(i);
        send(5, -1);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'h7ABC;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("abort_done", 32'(done), 32'd0);
        rd(5'd5, 16'h0015);
        for (int i = 0; i < N; i++) vec[i] = 16'h8000 + 16'(i);
        expect_res(5'd31, 16'h801F, 1'b1);
        send(32, -1);
        wait_done();
        pulse_clear();

        // Reset after 12 accepts, then a fresh vector
        for (int i = 0; i < 12; i++) vec[i] = 16'h7000;
        send(12, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_max_val", 32'(max_val), 32'd0);
        for (int i = 0; i < N; i++) vec[i] = 16'(i);
        vec[20] = 16'h0500;
        expect_res(5'd20, 16'h0500, 1'b0);
        send(32, 31);
        wait_done();
        pulse_clear();

        repeat (3) tick();
        chk("res_q_drained", 32'(res_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
